// File: rtl/button_event_pkg.sv
// Shared types for the button event decoder: FSM state encoding and the
// counter-width helper used to size the hold/gap counter.
package button_event_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESS1,
      WAIT2,
      PRESS2,
      LONG
   } state_e;

   // Counter must hold the larger of the two terminal counts.
   function automatic int cnt_width(input int long_c, input int gap_c);
      int max_c;
      max_c = (long_c > gap_c) ? long_c : gap_c;
      return $clog2(max_c + 1);
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers the previous sample of a synchronous level and flags rising and
// falling transitions combinationally against it.
module edge_detect (
   input  logic clk,
   input  logic lvl_i,
   output logic rise_o,
   output logic fall_o
);

   logic lvl_q;

   // Loads every edge, including under reset, so a level held through reset
   // is not reported as a new rise afterwards.
   always_ff @(posedge clk) begin
      lvl_q <= lvl_i;
   end

   assign rise_o = lvl_i & ~lvl_q;
   assign fall_o = ~lvl_i & lvl_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle press/release/click/
// double-click/long-press events plus a long-held level.
module button_event_decoder
   import button_event_pkg::*;
#(
   parameter int LONG_CYCLES = 50_000_000,
   parameter int GAP_CYCLES  = 12_500_000,
   parameter int CNT_W       = cnt_width(LONG_CYCLES, GAP_CYCLES)
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   btnIn,
   output logic   pressPulse,
   output logic   releasePulse,
   output logic   clickPulse,
   output logic   doubleClickPulse,
   output logic   longPulse,
   output logic   longHeld,
   output state_e dbgState
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   logic             rise, fall;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, release_q, click_q, dbl_q, long_q, held_q;
   logic             click_d, dbl_d, long_d;

   edge_detect u_edge (
      .clk    (clk),
      .lvl_i  (btnIn),
      .rise_o (rise),
      .fall_o (fall)
   );

   always_comb begin
      state_d = state_q;
      click_d = 1'b0;
      dbl_d   = 1'b0;
      long_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) state_d = PRESS1;
         end
         PRESS1: begin
            if (fall) begin
               state_d = WAIT2;
            end else if (cnt_q == LONG_LAST && btnIn) begin
               long_d  = 1'b1;
               state_d = LONG;
            end
         end
         WAIT2: begin
            // Timeout has priority; a rise on the same edge starts a fresh press.
            if (cnt_q == GAP_LAST) begin
               click_d = 1'b1;
               state_d = rise ? PRESS1 : IDLE;
            end else if (rise) begin
               state_d = PRESS2;
            end
         end
         PRESS2: begin
            if (fall) begin
               dbl_d   = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == LONG_LAST && btnIn) begin
               click_d = 1'b1;
               long_d  = 1'b1;
               state_d = LONG;
            end
         end
         LONG: begin
            if (fall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      cnt_d = '0;
      if (state_d == state_q && state_q inside {PRESS1, WAIT2, PRESS2}) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         click_q   <= 1'b0;
         dbl_q     <= 1'b0;
         long_q    <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_q   <= rise;
         release_q <= fall;
         click_q   <= click_d;
         dbl_q     <= dbl_d;
         long_q    <= long_d;
         held_q    <= (state_d == LONG);
      end
   end

   assign pressPulse       = press_q;
   assign releasePulse     = release_q;
   assign clickPulse       = click_q;
   assign doubleClickPulse = dbl_q;
   assign longPulse        = long_q;
   assign longHeld         = held_q;
   assign dbgState         = state_q;

endmodule
